// File: rtl/fp16_to_int16_pipe.sv
// Three-stage binary16 -> int16 converter: unpack/classify, align, round/saturate.
// Define FP2INT_STICKY_FLAGS_EN to make invalid/overflow/inexact accumulate until clr.
module fp16_to_int16_pipe #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        d_valid,
  input  logic [15:0] d,
  input  logic [1:0]  rm,
  output logic        q_valid,
  output logic [15:0] q,
  output logic        invalid,
  output logic        overflow,
  output logic        inexact
);

  if (LAT != 3) begin : g_bad_lat
    $error("fp16_to_int16_pipe: LAT is fixed at 3");
  end

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_NEG = 2'b01;
  localparam logic [1:0] RM_POS = 2'b10;

  // ---------------- stage 1: unpack / classify ----------------
  logic       s1_valid;
  logic       s1_sign;
  logic [4:0] s1_exp;
  logic [10:0] s1_sig;
  cls_t       s1_cls;
  logic [1:0] s1_rm;
  cls_t       in_cls;

  always_comb begin
    in_cls = CLS_ZERO;
    if (d[14:10] == 5'h1F) in_cls = (d[9:0] != 10'd0) ? CLS_NAN : CLS_INF;
    else if (d[14:10] != 5'd0) in_cls = CLS_NORM;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= 5'd0;
      s1_sig   <= 11'd0;
      s1_cls   <= CLS_ZERO;
      s1_rm    <= 2'd0;
    end else if (en) begin
      s1_valid <= d_valid;
      s1_sign  <= d[15];
      s1_exp   <= d[14:10];
      s1_sig   <= {(d[14:10] != 5'd0), d[9:0]};
      s1_cls   <= in_cls;
      s1_rm    <= rm;
    end
  end

  // ---------------- stage 2: align ----------------
  // Shifting by exp-14 puts the binary point between bits 11 and 10 of wide,
  // so bit 10 is the guard and bits 9:0 feed the sticky.
  logic [4:0]  sh;
  logic [26:0] wide;
  logic [16:0] al_mag;
  logic        al_guard;
  logic        al_sticky;
  logic        al_pre_ovf;

  assign sh   = s1_exp - 5'd14;
  assign wide = {16'd0, s1_sig} << sh;

  always_comb begin
    al_mag     = 17'd0;
    al_guard   = 1'b0;
    al_sticky  = 1'b0;
    al_pre_ovf = 1'b0;
    if (s1_cls == CLS_NORM) begin
      if (s1_exp >= 5'd14) begin
        al_mag    = {1'b0, wide[26:11]};
        al_guard  = wide[10];
        al_sticky = |wide[9:0];
      end else begin
        al_sticky = 1'b1;
      end
      if (s1_exp == 5'd30 && !(s1_sign && s1_sig[9:0] == 10'd0))
        al_pre_ovf = 1'b1;
    end else if (s1_cls == CLS_ZERO) begin
      al_sticky = |s1_sig[9:0];
    end
  end

  logic        s2_valid;
  logic        s2_sign;
  cls_t        s2_cls;
  logic [1:0]  s2_rm;
  logic [16:0] s2_mag;
  logic        s2_guard;
  logic        s2_sticky;
  logic        s2_pre_ovf;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_cls     <= CLS_ZERO;
      s2_rm      <= 2'd0;
      s2_mag     <= 17'd0;
      s2_guard   <= 1'b0;
      s2_sticky  <= 1'b0;
      s2_pre_ovf <= 1'b0;
    end else if (en) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_cls     <= s1_cls;
      s2_rm      <= s1_rm;
      s2_mag     <= al_mag;
      s2_guard   <= al_guard;
      s2_sticky  <= al_sticky;
      s2_pre_ovf <= al_pre_ovf;
    end
  end

  // ---------------- stage 3: round / saturate ----------------
  logic        inc;
  logic [16:0] mag_r;
  logic        too_big;
  logic [15:0] res_q;
  logic        res_inv;
  logic        res_ovf;
  logic        res_inx;

  always_comb begin
    inc = 1'b0;
    case (s2_rm)
      RM_RNE:  inc = s2_guard & (s2_sticky | s2_mag[0]);
      RM_NEG:  inc = s2_sign & (s2_guard | s2_sticky);
      RM_POS:  inc = !s2_sign & (s2_guard | s2_sticky);
      default: inc = 1'b0;
    endcase
  end

  assign mag_r   = s2_mag + {16'd0, inc};
  assign too_big = s2_sign ? (mag_r > 17'd32768) : (mag_r > 17'd32767);

  always_comb begin
    res_q   = 16'd0;
    res_inv = 1'b0;
    res_ovf = 1'b0;
    res_inx = 1'b0;
    if (s2_cls == CLS_NAN) begin
      res_q   = 16'h8000;
      res_inv = 1'b1;
    end else if (s2_cls == CLS_INF || s2_pre_ovf || too_big) begin
      res_q   = s2_sign ? 16'h8000 : 16'h7FFF;
      res_ovf = 1'b1;
    end else begin
      res_q   = s2_sign ? (16'd0 - mag_r[15:0]) : mag_r[15:0];
      res_inx = s2_guard | s2_sticky;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_valid  <= 1'b0;
      q        <= 16'd0;
      invalid  <= 1'b0;
      overflow <= 1'b0;
      inexact  <= 1'b0;
    end else if (en) begin
      q_valid <= s2_valid;
      if (s2_valid) begin
        q <= res_q;
`ifdef FP2INT_STICKY_FLAGS_EN
        invalid  <= invalid | res_inv;
        overflow <= overflow | res_ovf;
        inexact  <= inexact | res_inx;
`else
        invalid  <= res_inv;
        overflow <= res_ovf;
        inexact  <= res_inx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp16_to_int16_pipe.sv
// Directed bench for fp16_to_int16_pipe with hand-computed expected results.
// Flag expectations follow FP2INT_STICKY_FLAGS_EN when it is defined.
module tb_fp16_to_int16_pipe;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic        d_valid;
  logic [15:0] d;
  logic [1:0]  rm;
  logic        q_valid;
  logic [15:0] q;
  logic        invalid;
  logic        overflow;
  logic        inexact;

  int tests_run = 0;
  int tests_failed = 0;
  logic acc_inv = 1'b0;
  logic acc_ovf = 1'b0;
  logic acc_inx = 1'b0;

  fp16_to_int16_pipe #(.LAT(3)) dut (
    .clk(clk), .clr(clr), .en(en), .d_valid(d_valid), .d(d), .rm(rm),
    .q_valid(q_valid), .q(q), .invalid(invalid), .overflow(overflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests_run++;
    assert (got === want) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // One isolated conversion: sampled at the first edge, checked just after the third.
  task automatic apply_stimulus(input logic [15:0] val, input logic [1:0] mode,
                                input logic [15:0] want_q, input logic wi, input logic wo,
                                input logic wx, input string tag);
    logic ei, eo, ex;
    @(negedge clk);
    en = 1'b1; d_valid = 1'b1; d = val; rm = mode;
    @(negedge clk);
    d_valid = 1'b0; d = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef FP2INT_STICKY_FLAGS_EN
    acc_inv = acc_inv | wi; acc_ovf = acc_ovf | wo; acc_inx = acc_inx | wx;
    ei = acc_inv; eo = acc_ovf; ex = acc_inx;
`else
    ei = wi; eo = wo; ex = wx;
`endif
    check_output({tag, ".q_valid"}, {15'd0, q_valid}, 16'd1);
    check_output({tag, ".q"}, q, want_q);
    check_output({tag, ".invalid"}, {15'd0, invalid}, {15'd0, ei});
    check_output({tag, ".overflow"}, {15'd0, overflow}, {15'd0, eo});
    check_output({tag, ".inexact"}, {15'd0, inexact}, {15'd0, ex});
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; d_valid = 1'b0; d = 16'h0000; rm = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset.q_valid", {15'd0, q_valid}, 16'd0);
    check_output("reset.q", q, 16'd0);
    check_output("reset.flags", {13'd0, invalid, overflow, inexact}, 16'd0);
    @(negedge clk);
    clr = 1'b0;

    apply_stimulus(16'h4500, 2'b00, 16'h0005, 1'b0, 1'b0, 1'b0, "five");
    apply_stimulus(16'h4A00, 2'b00, 16'h000C, 1'b0, 1'b0, 1'b0, "twelve");
    apply_stimulus(16'hBE00, 2'b00, 16'hFFFE, 1'b0, 1'b0, 1'b1, "m1p5_rne");
    apply_stimulus(16'hBE00, 2'b01, 16'hFFFE, 1'b0, 1'b0, 1'b1, "m1p5_neg");
    apply_stimulus(16'hBE00, 2'b10, 16'hFFFF, 1'b0, 1'b0, 1'b1, "m1p5_pos");
    apply_stimulus(16'hBE00, 2'b11, 16'hFFFF, 1'b0, 1'b0, 1'b1, "m1p5_rtz");
    apply_stimulus(16'h4100, 2'b00, 16'h0002, 1'b0, 1'b0, 1'b1, "tie_2p5");
    apply_stimulus(16'h4300, 2'b00, 16'h0004, 1'b0, 1'b0, 1'b1, "tie_3p5");
    apply_stimulus(16'h3800, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, "half_rne");
    apply_stimulus(16'h3A00, 2'b00, 16'h0001, 1'b0, 1'b0, 1'b1, "p75_rne");
    apply_stimulus(16'h8000, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, "neg_zero");
    apply_stimulus(16'h0001, 2'b10, 16'h0001, 1'b0, 1'b0, 1'b1, "denorm_pos");
    apply_stimulus(16'h0001, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b1, "denorm_neg_rm");
    apply_stimulus(16'h8001, 2'b01, 16'hFFFF, 1'b0, 1'b0, 1'b1, "ndenorm_neg_rm");
    apply_stimulus(16'hF800, 2'b00, 16'h8000, 1'b0, 1'b0, 1'b0, "min_int");
    apply_stimulus(16'h7BFF, 2'b00, 16'h7FFF, 1'b0, 1'b1, 1'b0, "max_half");
    apply_stimulus(16'hFBFF, 2'b00, 16'h8000, 1'b0, 1'b1, 1'b0, "min_half");
    apply_stimulus(16'h7C00, 2'b00, 16'h7FFF, 1'b0, 1'b1, 1'b0, "pos_inf");
    apply_stimulus(16'h7E00, 2'b00, 16'h8000, 1'b1, 1'b0, 1'b0, "nan");

    // Back-to-back stream with two stalls while operands are in flight.
    @(negedge clk); en = 1'b1; d_valid = 1'b1; d = 16'h4500; rm = 2'b00;
    @(negedge clk); d = 16'h4300;
    @(negedge clk); en = 1'b0; d = 16'h7E00;
    @(posedge clk); #1;
    check_output("stream.stall1_qv", {15'd0, q_valid}, 16'd0);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    check_output("stream.stall2_qv", {15'd0, q_valid}, 16'd0);
    @(negedge clk); en = 1'b1; d = 16'hBE00;
    @(posedge clk); #1;
    check_output("stream.out1_q", q, 16'h0005);
    check_output("stream.out1_qv", {15'd0, q_valid}, 16'd1);
    @(negedge clk); en = 1'b0; d = 16'h7C00;
    @(posedge clk); #1;
    check_output("stream.hold_q", q, 16'h0005);
    check_output("stream.hold_qv", {15'd0, q_valid}, 16'd1);
    @(negedge clk); en = 1'b1; d_valid = 1'b0; d = 16'h0000;
    @(posedge clk); #1;
    check_output("stream.out2_q", q, 16'h0004);
    check_output("stream.out2_qv", {15'd0, q_valid}, 16'd1);
    @(posedge clk); #1;
    check_output("stream.out3_q", q, 16'hFFFE);
    check_output("stream.out3_qv", {15'd0, q_valid}, 16'd1);
    @(posedge clk); #1;
    check_output("stream.bubble_qv", {15'd0, q_valid}, 16'd0);
    check_output("stream.bubble_q", q, 16'hFFFE);

    // Clear with two operands in flight.
    @(negedge clk); en = 1'b1; d_valid = 1'b1; d = 16'h4500;
    @(negedge clk); d = 16'h4A00;
    @(negedge clk); d_valid = 1'b0; d = 16'h0000; clr = 1'b1;
    #1;
    acc_inv = 1'b0; acc_ovf = 1'b0; acc_inx = 1'b0;
    check_output("clr.q_valid", {15'd0, q_valid}, 16'd0);
    check_output("clr.q", q, 16'd0);
    check_output("clr.flags", {13'd0, invalid, overflow, inexact}, 16'd0);
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_output("clr.no_late_qv", {15'd0, q_valid}, 16'd0);
    end

    // NaN followed by a clean result: invalid clears unless flags are sticky.
    apply_stimulus(16'h7E00, 2'b00, 16'h8000, 1'b1, 1'b0, 1'b0, "sticky_nan");
    apply_stimulus(16'h4500, 2'b00, 16'h0005, 1'b0, 1'b0, 1'b0, "sticky_five");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
